// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: PC path-select codes and FSM states.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        PS_HOLD = 2'b00,
        PS_INC  = 2'b01,
        PS_LOAD = 2'b10,
        PS_REL  = 2'b11
    } ps_e;

    typedef enum logic [1:0] {
        RST_WAIT = 2'b00,
        REQ      = 2'b01,
        STALL    = 2'b10,
        ERR      = 2'b11
    } state_e;

    // Absolute redirects load the target; relative ones let the PC add (offset << 2).
    function automatic ps_e redirect_ps(input logic is_abs);
        return is_abs ? PS_LOAD : PS_REL;
    endfunction

endpackage

// File: rtl/pc_redirect_buffer.sv
// One-entry holding register for a branch/jump redirect accepted from decode.
module pc_redirect_buffer
    import pc_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        capture,
    input  logic        clear,
    input  logic        abs_in,
    input  logic [31:0] target_in,
    output logic        valid,
    output logic        abs,
    output logic [31:0] target,
    output logic        br_ready
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid  <= 1'b0;
            abs    <= 1'b0;
            target <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid  <= 1'b1;
            abs    <= abs_in;
            target <= target_in;
        end
    end

    assign br_ready = enable && !valid;

endmodule

// File: rtl/pc_sequencer.sv
// Per-cycle PC controller: fetch handshake, redirect buffering/flush and fetch watchdog.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_abs,
    input  logic [31:0] br_target,
    output logic        br_ready,
    output logic [1:0]  PS,
    output logic [31:0] pc_in,
    output logic        fetch_valid,
    output logic        flush,
    output logic        err_timeout
);

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             err_q, err_d;
    ps_e              ps;
    logic             buf_valid, buf_abs, buf_clear, buf_capture, bypass;
    logic [31:0]      buf_target;

    pc_redirect_buffer u_redirect_buffer (
        .clock     (clock),
        .reset     (reset),
        .enable    (state_q != ERR),
        .capture   (buf_capture),
        .clear     (buf_clear),
        .abs_in    (br_abs),
        .target_in (br_target),
        .valid     (buf_valid),
        .abs       (buf_abs),
        .target    (buf_target),
        .br_ready  (br_ready)
    );

    // A redirect taken straight from decode on an ack cycle is never also captured.
    assign buf_capture = br_valid && br_ready && !bypass;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RST_WAIT;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wd_d        = '0;
        err_d       = err_q;
        imem_req    = 1'b0;
        ps          = PS_HOLD;
        pc_in       = '0;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        buf_clear   = 1'b0;
        bypass      = 1'b0;
        unique case (state_q)
            RST_WAIT: state_d = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (!imem_ack) begin
                    if (wd_q >= WD_LAST) begin
                        wd_d    = WD_MAX;
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end else if (buf_valid) begin
                    flush     = 1'b1;
                    ps        = redirect_ps(buf_abs);
                    pc_in     = buf_target;
                    buf_clear = 1'b1;
                end else if (br_valid) begin
                    flush  = 1'b1;
                    ps     = redirect_ps(br_abs);
                    pc_in  = br_target;
                    bypass = 1'b1;
                end else begin
                    fetch_valid = 1'b1;
                    if (!stall) ps = PS_INC;
                    else        state_d = STALL;
                end
            end
            STALL: begin
                if (buf_valid) begin
                    flush     = 1'b1;
                    ps        = redirect_ps(buf_abs);
                    pc_in     = buf_target;
                    buf_clear = 1'b1;
                end
                if (!stall) state_d = REQ;
            end
            ERR: ;
            default: state_d = RST_WAIT;
        endcase
    end

    assign PS          = ps;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer with a reference PC register.
module tb_pc_sequencer;

    logic        clock, reset;
    logic        imem_req, imem_ack, stall, br_valid, br_abs, br_ready;
    logic [31:0] br_target, pc_in;
    logic [1:0]  PS;
    logic        fetch_valid, flush, err_timeout;
    logic [31:0] pc;

    int checks = 0;
    int fails  = 0;

    pc_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .stall       (stall),
        .br_valid    (br_valid),
        .br_abs      (br_abs),
        .br_target   (br_target),
        .br_ready    (br_ready),
        .PS          (PS),
        .pc_in       (pc_in),
        .fetch_valid (fetch_valid),
        .flush       (flush),
        .err_timeout (err_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Program counter driven by the sequencer's select/operand outputs.
    always @(posedge clock or negedge reset) begin
        if (!reset) pc <= 32'h8000_0000;
        else begin
            case (PS)
                2'b01:   pc <= pc + 32'd4;
                2'b10:   pc <= pc_in;
                2'b11:   pc <= pc + (pc_in << 2);
                default: pc <= pc;
            endcase
        end
    end

    typedef struct {
        logic        ack, stl, bv, babs;
        logic [31:0] btgt;
        logic        req, rdy;
        logic [1:0]  ps;
        logic [31:0] pin, pcv;
        logic        fv, fl, err;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic ack, stl, bv, babs, input logic [31:0] btgt,
                                input logic req, rdy, input logic [1:0] ps,
                                input logic [31:0] pin, pcv, input logic fv, fl, err);
        vec_t v;
        v.ack = ack; v.stl = stl; v.bv = bv; v.babs = babs; v.btgt = btgt;
        v.req = req; v.rdy = rdy; v.ps = ps; v.pin = pin; v.pcv = pcv;
        v.fv = fv; v.fl = fl; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ack, stl, bv, babs, input logic [31:0] btgt);
        imem_ack = ack; stall = stl; br_valid = bv; br_abs = babs; br_target = btgt;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(imem_req),    32'd0);
        chk({tag, "_rdy"},   32'(br_ready),    32'd1);
        chk({tag, "_ps"},    32'(PS),          32'd0);
        chk({tag, "_pin"},   pc_in,            32'd0);
        chk({tag, "_fv"},    32'(fetch_valid), 32'd0);
        chk({tag, "_flush"}, 32'(flush),       32'd0);
        chk({tag, "_err"},   32'(err_timeout), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        //        ack stl bv abs target        | req rdy ps pc_in         pc            fv fl err
        tv.push_back(mk(1, 0, 0, 0, 32'h0,         0, 1, 2'd0, 32'h0,         32'h8000_0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 32'h0,         1, 1, 2'd1, 32'h0,         32'h8000_0000, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 32'h0,         1, 1, 2'd1, 32'h0,         32'h8000_0004, 1, 0, 0));
        tv.push_back(mk(1, 0, 1, 1, 32'h8000_1000, 1, 1, 2'd2, 32'h8000_1000, 32'h8000_0008, 0, 1, 0));
        tv.push_back(mk(1, 0, 0, 0, 32'h0,         1, 1, 2'd1, 32'h0,         32'h8000_1000, 1, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 32'hFFFF_FFFE, 1, 1, 2'd0, 32'h0,         32'h8000_1004, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,         1, 0, 2'd0, 32'h0,         32'h8000_1004, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 1, 32'h8000_2000, 1, 0, 2'd0, 32'h0,         32'h8000_1004, 0, 0, 0));
        tv.push_back(mk(1, 0, 1, 1, 32'h8000_2000, 1, 0, 2'd3, 32'hFFFF_FFFE, 32'h8000_1004, 0, 1, 0));
        tv.push_back(mk(1, 0, 1, 1, 32'h8000_2000, 1, 1, 2'd2, 32'h8000_2000, 32'h8000_0FFC, 0, 1, 0));
        tv.push_back(mk(1, 1, 0, 0, 32'h0,         1, 1, 2'd0, 32'h0,         32'h8000_2000, 1, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 32'h0,         0, 1, 2'd0, 32'h0,         32'h8000_2000, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 32'h0,         0, 1, 2'd0, 32'h0,         32'h8000_2000, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 32'h0,         1, 1, 2'd1, 32'h0,         32'h8000_2000, 1, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 32'h0,         1, 1, 2'd0, 32'h0,         32'h8000_2004, 1, 0, 0));
        tv.push_back(mk(1, 1, 1, 1, 32'h8000_3000, 0, 1, 2'd0, 32'h0,         32'h8000_2004, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 32'h0,         0, 0, 2'd2, 32'h8000_3000, 32'h8000_2004, 0, 1, 0));
        tv.push_back(mk(1, 0, 0, 0, 32'h0,         0, 1, 2'd0, 32'h0,         32'h8000_3000, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 32'h0,         1, 1, 2'd1, 32'h0,         32'h8000_3000, 1, 0, 0));

        repeat (2) @(negedge clock);
        #1 chk_reset_outputs("rst_held");

        @(negedge clock);
        reset = 1'b1;
        foreach (tv[i]) begin
            drive(tv[i].ack, tv[i].stl, tv[i].bv, tv[i].babs, tv[i].btgt);
            #1;
            chk($sformatf("v%0d_req", i),   32'(imem_req),    32'(tv[i].req));
            chk($sformatf("v%0d_rdy", i),   32'(br_ready),    32'(tv[i].rdy));
            chk($sformatf("v%0d_ps", i),    32'(PS),          32'(tv[i].ps));
            chk($sformatf("v%0d_pin", i),   pc_in,            tv[i].pin);
            chk($sformatf("v%0d_pc", i),    pc,               tv[i].pcv);
            chk($sformatf("v%0d_fv", i),    32'(fetch_valid), 32'(tv[i].fv));
            chk($sformatf("v%0d_flush", i), 32'(flush),       32'(tv[i].fl));
            chk($sformatf("v%0d_err", i),   32'(err_timeout), 32'(tv[i].err));
            @(negedge clock);
        end

        // Watchdog: four unacknowledged request cycles, then sticky error.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            #1;
            chk($sformatf("wd%0d_req", i), 32'(imem_req),    32'd1);
            chk($sformatf("wd%0d_err", i), 32'(err_timeout), 32'd0);
            @(negedge clock);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_4000);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("err%0d_err", i),   32'(err_timeout), 32'd1);
            chk($sformatf("err%0d_req", i),   32'(imem_req),    32'd0);
            chk($sformatf("err%0d_rdy", i),   32'(br_ready),    32'd0);
            chk($sformatf("err%0d_ps", i),    32'(PS),          32'd0);
            chk($sformatf("err%0d_flush", i), 32'(flush),       32'd0);
            chk($sformatf("err%0d_fv", i),    32'(fetch_valid), 32'd0);
            @(negedge clock);
        end
        #2 reset = 1'b0;
        #1 chk_reset_outputs("err_clr");

        // Reset asserted mid-cycle while a relative redirect sits in the buffer.
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        #1 chk("rb_wait_ps", 32'(PS), 32'd0);
        chk("rb_wait_req", 32'(imem_req), 32'd0);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
        #1 chk("rb_cap_rdy", 32'(br_ready), 32'd1);
        chk("rb_cap_req", 32'(imem_req), 32'd1);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        #1 chk("rb_full_rdy", 32'(br_ready), 32'd0);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("rb_async");
        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        #1 chk("rb_rel_ps", 32'(PS), 32'd0);
        chk("rb_rel_req", 32'(imem_req), 32'd0);
        @(negedge clock);
        #1 chk("rb_fetch_ps", 32'(PS), 32'd1);
        chk("rb_fetch_pin", pc_in, 32'd0);
        chk("rb_fetch_flush", 32'(flush), 32'd0);
        chk("rb_fetch_fv", 32'(fetch_valid), 32'd1);
        chk("rb_fetch_rdy", 32'(br_ready), 32'd1);
        chk("rb_fetch_pc", pc, 32'h8000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
